// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage between fetch and execute: decodes every
// RV32I/RV64I immediate format, optionally forms pc+imm, and buffers via a 2-entry skid.
module imm_decode_stage #(
  parameter int XLEN   = 32,
  parameter bit TGT_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_ZIMM  = 3'd6;
  localparam logic [2:0] FMT_SHAMT = 3'd7;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] tgt;
    logic            ill;
  } entry_t;

  entry_t          dec;
  entry_t          main_q;
  entry_t          skid_q;
  logic            main_v;
  logic            skid_v;
  logic            rdy_q;

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z, imm_sh, imm_sh5;
  logic [5:0]      shamt6;
  logic [2:0]      f3;
  logic            f3_shift;

  assign f3       = in_inst[14:12];
  assign f3_shift = (f3 == 3'b001) || (f3 == 3'b101);
  assign shamt6   = (XLEN == 64) ? in_inst[25:20] : {1'b0, in_inst[24:20]};

  assign imm_i   = XLEN'($signed(in_inst[31:20]));
  assign imm_s   = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b   = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
  assign imm_u   = XLEN'($signed({in_inst[31:12], 12'h000}));
  assign imm_j   = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
  assign imm_z   = XLEN'(in_inst[19:15]);
  assign imm_sh  = XLEN'(shamt6);
  assign imm_sh5 = XLEN'(in_inst[24:20]);

  // Decode is purely combinational on the offered word; only the result is registered.
  always_comb begin
    dec      = '0;
    dec.inst = in_inst;
    dec.pc   = in_pc;
    dec.ill  = 1'b0;
    if (in_inst[1:0] != 2'b11) begin
      dec.ill = 1'b1;
    end else begin
      case (in_inst[6:0])
        7'b0000011, 7'b1100111, 7'b0001111: begin dec.fmt = FMT_I; dec.imm = imm_i; end
        7'b0010011: begin
          if (f3_shift) begin dec.fmt = FMT_SHAMT; dec.imm = imm_sh; end
          else          begin dec.fmt = FMT_I;     dec.imm = imm_i;  end
        end
        7'b0100011: begin dec.fmt = FMT_S; dec.imm = imm_s; end
        7'b1100011: begin dec.fmt = FMT_B; dec.imm = imm_b; end
        7'b0110111, 7'b0010111: begin dec.fmt = FMT_U; dec.imm = imm_u; end
        7'b1101111: begin dec.fmt = FMT_J; dec.imm = imm_j; end
        7'b1110011: begin
          if (f3[2]) begin dec.fmt = FMT_ZIMM; dec.imm = imm_z; end
          else       begin dec.fmt = FMT_I;    dec.imm = imm_i; end
        end
        7'b0110011: dec.fmt = FMT_NONE;
        7'b0011011: begin
          if (XLEN != 64)    dec.ill = 1'b1;
          else if (f3_shift) begin dec.fmt = FMT_SHAMT; dec.imm = imm_sh5; end
          else               begin dec.fmt = FMT_I;     dec.imm = imm_i;   end
        end
        7'b0111011: dec.ill = (XLEN != 64);
        default:    dec.ill = 1'b1;
      endcase
    end
    dec.tgt = TGT_EN ? (in_pc + dec.imm) : '0;
  end

  // Handshake: a word moves on a rising edge only when its valid and ready are both
  // high; valid never waits on ready, and in_ready is exactly ~skid_v held in a flop.
  logic acc, xfer;
  assign acc  = in_valid & rdy_q;
  assign xfer = main_v & out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_q <= '0;
      skid_q <= '0;
      main_v <= 1'b0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b1;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b1;
    end else if (xfer) begin
      if (skid_v) begin
        main_q <= skid_q;
        skid_v <= 1'b0;
        rdy_q  <= 1'b1;
      end else if (acc) begin
        main_q <= dec;
      end else begin
        main_v <= 1'b0;
      end
    end else if (acc) begin
      if (!main_v) begin
        main_q <= dec;
        main_v <= 1'b1;
      end else begin
        skid_q <= dec;
        skid_v <= 1'b1;
        rdy_q  <= 1'b0;
      end
    end
  end

  assign in_ready    = rdy_q;
  assign out_valid   = main_v;
  assign out_inst    = main_q.inst;
  assign out_pc      = main_q.pc;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_target  = main_q.tgt;
  assign out_illegal = main_q.ill;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: XLEN=32 and XLEN=64 instances share one stimulus
// stream and are compared against an arithmetic decode model and a 2-deep queue.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = '0;
  logic [63:0] in_pc = '0;
  logic        out_ready = 1'b0;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_inst32, out_pc32, out_imm32, out_target32;
  logic [2:0]  out_fmt32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [31:0] out_inst64;
  logic [63:0] out_pc64, out_imm64, out_target64;
  logic [2:0]  out_fmt64;

  int errors = 0;
  int checks = 0;
  logic [95:0] exp_q[$];
  bit          last_acc;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .TGT_EN(1'b1)) dut32 (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(out_valid32), .out_ready(out_ready),
    .out_inst(out_inst32), .out_pc(out_pc32), .out_imm(out_imm32), .out_fmt(out_fmt32),
    .out_target(out_target32), .out_illegal(out_illegal32)
  );

  imm_decode_stage #(.XLEN(64), .TGT_EN(1'b1)) dut64 (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid64), .out_ready(out_ready),
    .out_inst(out_inst64), .out_pc(out_pc64), .out_imm(out_imm64), .out_fmt(out_fmt64),
    .out_target(out_target64), .out_illegal(out_illegal64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Immediates built from signed arithmetic on the word rather than bit concatenation.
  function automatic void ref_decode(input logic [31:0] inst, input logic [63:0] pc,
                                     input int xlen, output logic [63:0] imm,
                                     output logic [2:0] fmt, output logic ill,
                                     output logic [63:0] tgt);
    longint      s, hi;
    logic [63:0] mask;
    logic [2:0]  f3;
    bit          sh;
    s = 0; fmt = 3'd0; ill = 1'b0;
    mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    f3 = inst[14:12];
    sh = (f3 == 3'd1) || (f3 == 3'd5);
    if (inst[1:0] != 2'b11) ill = 1'b1;
    else begin
      case (inst[6:0])
        7'h03, 7'h67, 7'h0F: fmt = 3'd1;
        7'h13: fmt = sh ? 3'd7 : 3'd1;
        7'h23: fmt = 3'd2;
        7'h63: fmt = 3'd3;
        7'h37, 7'h17: fmt = 3'd4;
        7'h6F: fmt = 3'd5;
        7'h73: fmt = f3[2] ? 3'd6 : 3'd1;
        7'h33: fmt = 3'd0;
        7'h1B: if (xlen == 64) fmt = sh ? 3'd7 : 3'd1; else ill = 1'b1;
        7'h3B: if (xlen != 64) ill = 1'b1;
        default: ill = 1'b1;
      endcase
    end
    hi = longint'($signed(inst));
    case (fmt)
      3'd1: s = hi >>> 20;
      3'd2: s = (hi >>> 25) * 32 + longint'(inst[11:7]);
      3'd3: s = (hi >>> 31) * 4096 + longint'(inst[7]) * 2048 + longint'(inst[30:25]) * 32
                + longint'(inst[11:8]) * 2;
      3'd4: s = (hi >>> 12) * 4096;
      3'd5: s = (hi >>> 31) * 1048576 + longint'(inst[19:12]) * 4096 + longint'(inst[20]) * 2048
                + longint'(inst[30:21]) * 2;
      3'd6: s = longint'(inst[19:15]);
      3'd7: s = (xlen == 64 && inst[6:0] == 7'h13) ? longint'(inst[25:20]) : longint'(inst[24:20]);
      default: s = 0;
    endcase
    imm = 64'(s) & mask;
    tgt = (pc + 64'(s)) & mask;
  endfunction

  task automatic check_state();
    logic [31:0] inst;
    logic [63:0] pc, imm, tgt;
    logic [2:0]  fmt;
    logic        ill;
    check("valid32", {63'b0, out_valid32}, {63'b0, exp_q.size() > 0});
    check("ready32", {63'b0, in_ready32}, {63'b0, exp_q.size() < 2});
    check("valid64", {63'b0, out_valid64}, {63'b0, exp_q.size() > 0});
    check("ready64", {63'b0, in_ready64}, {63'b0, exp_q.size() < 2});
    if (exp_q.size() > 0) begin
      {inst, pc} = exp_q[0];
      ref_decode(inst, pc, 32, imm, fmt, ill, tgt);
      check("inst32", {32'b0, out_inst32}, {32'b0, inst});
      check("pc32", {32'b0, out_pc32}, {32'b0, pc[31:0]});
      check("imm32", {32'b0, out_imm32}, imm);
      check("fmt32", {61'b0, out_fmt32}, {61'b0, fmt});
      check("ill32", {63'b0, out_illegal32}, {63'b0, ill});
      check("tgt32", {32'b0, out_target32}, tgt);
      ref_decode(inst, pc, 64, imm, fmt, ill, tgt);
      check("inst64", {32'b0, out_inst64}, {32'b0, inst});
      check("pc64", out_pc64, pc);
      check("imm64", out_imm64, imm);
      check("fmt64", {61'b0, out_fmt64}, {61'b0, fmt});
      check("ill64", {63'b0, out_illegal64}, {63'b0, ill});
      check("tgt64", out_target64, tgt);
    end
  endtask

  // Called at a negedge: check, drive, advance the queue model, then step one clock.
  task automatic cycle(input bit v, input logic [31:0] inst, input logic [63:0] pc,
                       input bit ordy, input bit fl);
    bit acc, xf;
    check_state();
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
    acc = v && (exp_q.size() < 2);
    xf  = ordy && (exp_q.size() > 0);
    last_acc = 1'b0;
    if (fl) exp_q.delete();
    else begin
      if (xf) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({inst, pc});
      last_acc = acc;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops[14] = '{7'h03, 7'h67, 7'h0F, 7'h13, 7'h23, 7'h63, 7'h37,
                             7'h17, 7'h6F, 7'h73, 7'h33, 7'h1B, 7'h3B, 7'h7F};
    logic [31:0] r;
    r = $urandom;
    r[6:0] = ops[$urandom_range(0, 13)];
    if ($urandom_range(0, 15) == 0) r[1:0] = 2'($urandom_range(0, 2));
    return r;
  endfunction

  function automatic logic [63:0] rand_pc();
    return {$urandom, $urandom};
  endfunction

  initial begin
    // Reset values
    #12;
    check("rst_valid", {63'b0, out_valid32}, 64'd0);
    check("rst_ready", {63'b0, in_ready32}, 64'd1);
    check("rst_imm", {32'b0, out_imm32}, 64'd0);
    check("rst_tgt64", out_target64, 64'd0);
    check("rst_inst64", {32'b0, out_inst64}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Directed decode cases
    cycle(1, 32'hFFF00093, 64'h0, 1, 0);
    check("addi_valid", {63'b0, out_valid32}, 64'd1);
    check("addi_fmt", {61'b0, out_fmt32}, 64'd1);
    check("addi_imm", {32'b0, out_imm32}, 64'h0000_0000_FFFF_FFFF);
    check("addi_ill", {63'b0, out_illegal32}, 64'd0);
    cycle(1, 32'hFE000EE3, 64'h100, 1, 0);
    check("beq_fmt", {61'b0, out_fmt32}, 64'd3);
    check("beq_imm", {32'b0, out_imm32}, 64'h0000_0000_FFFF_FFFC);
    check("beq_tgt", {32'b0, out_target32}, 64'h0000_0000_0000_00FC);
    cycle(1, 32'hFF9FF06F, 64'h0, 1, 0);
    check("jal_fmt", {61'b0, out_fmt32}, 64'd5);
    check("jal_wrap32", {32'b0, out_target32}, 64'h0000_0000_FFFF_FFF8);
    check("jal_wrap64", out_target64, 64'hFFFF_FFFF_FFFF_FFF8);
    cycle(1, 32'h03F09093, 64'h0, 1, 0);
    check("slli_fmt64", {61'b0, out_fmt64}, 64'd7);
    check("slli_imm64", out_imm64, 64'd63);
    check("slli_imm32", {32'b0, out_imm32}, 64'd31);
    cycle(1, 32'h0000007F, 64'h40, 1, 0);
    check("ill7f_ill", {63'b0, out_illegal32}, 64'd1);
    check("ill7f_imm", {32'b0, out_imm32}, 64'd0);
    cycle(1, 32'h00000092, 64'h44, 1, 0);
    check("ill92_ill", {63'b0, out_illegal64}, 64'd1);
    check("ill92_imm", out_imm64, 64'd0);
    cycle(1, 32'h000FD0F3, 64'h48, 1, 0);
    check("csrrwi_fmt", {61'b0, out_fmt32}, 64'd6);
    check("csrrwi_imm", {32'b0, out_imm32}, 64'd31);
    for (int i = 0; i < 3; i++) cycle(0, '0, '0, 1, 0);

    // Skid fill and drain in order
    cycle(1, 32'h00A00513, 64'h200, 0, 0);
    cycle(1, 32'h00B00593, 64'h204, 0, 0);
    check("skid_full_ready", {63'b0, in_ready32}, 64'd0);
    cycle(1, 32'h00C00613, 64'h208, 0, 0);
    check("skid_hold_inst", {32'b0, out_inst32}, 64'h0000_0000_00A0_0513);
    for (int i = 0; i < 6; i++) begin
      cycle(1, 32'h00C00613, 64'h208, 1, 0);
      if (last_acc) break;
    end
    for (int i = 0; i < 4; i++) cycle(0, '0, '0, 1, 0);

    // Flush with both entries full plus a word offered in the same cycle
    cycle(1, 32'h01100693, 64'h300, 0, 0);
    cycle(1, 32'h01200713, 64'h304, 0, 0);
    cycle(1, 32'h01300793, 64'h308, 0, 1);
    check("flush_valid", {63'b0, out_valid32}, 64'd0);
    check("flush_ready", {63'b0, in_ready64}, 64'd1);
    for (int i = 0; i < 3; i++) cycle(0, '0, '0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) < 7, rand_inst(), rand_pc(),
            $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
    end
    for (int i = 0; i < 4; i++) cycle(0, '0, '0, 1, 0);
    check_state();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
